lcd_hd44780_sequencer: RTL and testbench

//  Bus-cycle master for an HD44780-compatible character LCD. It drives the panel side of the same 8-bit
//  RS/RW/E/DATA interface that the Avalon LCD slave exposes raw. Sequencing is in hardware: setup, E pulse

---
 rtl/lcd_hd44780_pkg.sv | 38 +++
 rtl/lcd_phase_timer.sv | 34 +++
 rtl/lcd_hd44780_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_lcd_hd44780_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_hd44780_pkg.sv
// ============================================================================
// Module   : lcd_hd44780_pkg
// Brief    : Shared types and timing defaults for the HD44780 bus sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package lcd_hd44780_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_P_SETUP = 4'd1,
        ST_P_EH    = 4'd2,
        ST_P_HOLD  = 4'd3,
        ST_P_REC   = 4'd4,
        ST_A_SETUP = 4'd5,
        ST_A_EH    = 4'd6,
        ST_A_HOLD  = 4'd7,
        ST_A_REC   = 4'd8
    } state_t;

    typedef enum logic {RS_INSTR = 1'b0, RS_DATA  = 1'b1} rs_t;
    typedef enum logic {RW_WRITE = 1'b0, RW_READ  = 1'b1} rw_t;

    localparam int T_AS_DEF     = 2;
    localparam int T_EH_DEF     = 12;
    localparam int T_H_DEF      = 1;
    localparam int T_REC_DEF    = 10;
    localparam int POLL_EN_DEF  = 1;
    localparam int POLL_MAX_DEF = 4096;

    localparam int BF_BIT     = 7;
    localparam int TIMER_W    = 8;
    localparam int POLL_CNT_W = 13;

endpackage

`default_nettype wire

// File: rtl/lcd_phase_timer.sv
// ============================================================================
// Module   : lcd_phase_timer
// Brief    : Loadable down counter; done while the count sits at zero.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lcd_phase_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             done_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/lcd_hd44780_sequencer.sv
// ============================================================================
// Module   : lcd_hd44780_sequencer
// Brief    : HD44780 bus-cycle master with busy-flag polling and timed E strobe.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lcd_hd44780_sequencer
    import lcd_hd44780_pkg::*;
#(
    parameter int T_AS     = T_AS_DEF,
    parameter int T_EH     = T_EH_DEF,
    parameter int T_H      = T_H_DEF,
    parameter int T_REC    = T_REC_DEF,
    parameter int POLL_EN  = POLL_EN_DEF,
    parameter int POLL_MAX = POLL_MAX_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rs,
    input  logic       cmd_rw,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy_timeout,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    inout  wire  [7:0] LCD_data
);

    localparam logic [POLL_CNT_W-1:0] POLL_LIMIT = POLL_CNT_W'(POLL_MAX);
    localparam logic                  POLL_ON    = (POLL_EN != 0);

    state_t                  state_q, state_d;
    logic                    req_rs_q, req_rs_d, req_rw_q, req_rw_d;
    logic [7:0]              req_data_q, req_data_d;
    logic                    busy_q, busy_d;
    logic [POLL_CNT_W-1:0]   poll_cnt_q, poll_cnt_d;
    logic [7:0]              rd_sample_q, rd_sample_d;
    logic                    lcd_e_q, lcd_e_d, lcd_rs_q, lcd_rs_d, lcd_rw_q, lcd_rw_d;
    logic                    drive_q, drive_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [7:0]              rsp_data_q, rsp_data_d;
    logic                    timeout_q, timeout_d;

    logic                    w_accept, w_skip_poll, w_timer_done;
    logic [TIMER_W-1:0]      w_timer_val;

    function automatic logic [TIMER_W-1:0] phase_load(input state_t s);
        case (s)
            ST_P_SETUP, ST_A_SETUP: phase_load = TIMER_W'(T_AS - 1);
            ST_P_EH,    ST_A_EH:    phase_load = TIMER_W'(T_EH - 1);
            ST_P_HOLD,  ST_A_HOLD:  phase_load = TIMER_W'(T_H - 1);
            ST_P_REC,   ST_A_REC:   phase_load = TIMER_W'(T_REC - 1);
            default:                phase_load = '0;
        endcase
    endfunction

    assign w_accept    = (state_q == ST_IDLE) && cmd_valid && cmd_ready_q;
    // Busy/address reads are legal while the controller is busy, so they never poll.
    assign w_skip_poll = !POLL_ON || (cmd_rs == RS_INSTR && cmd_rw == RW_READ);
    assign w_timer_val = phase_load(state_d);

    lcd_phase_timer #(
        .WIDTH      (TIMER_W)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (state_d != state_q),
        .load_val_i (w_timer_val),
        .done_o     (w_timer_done)
    );

    always_comb begin
        state_d     = state_q;
        req_rs_d    = req_rs_q;
        req_rw_d    = req_rw_q;
        req_data_d  = req_data_q;
        busy_d      = busy_q;
        poll_cnt_d  = poll_cnt_q;
        rd_sample_d = rd_sample_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        timeout_d   = 1'b0;

        case (state_q)
            ST_IDLE: if (w_accept) begin
                req_rs_d   = cmd_rs;
                req_rw_d   = cmd_rw;
                req_data_d = cmd_data;
                poll_cnt_d = '0;
                state_d    = w_skip_poll ? ST_A_SETUP : ST_P_SETUP;
            end
            ST_P_SETUP: if (w_timer_done) state_d = ST_P_EH;
            ST_P_EH: if (w_timer_done) begin
                busy_d = LCD_data[BF_BIT];
                if (poll_cnt_q != '1) poll_cnt_d = poll_cnt_q + 1'b1;
                state_d = ST_P_HOLD;
            end
            ST_P_HOLD: if (w_timer_done) state_d = ST_P_REC;
            ST_P_REC: if (w_timer_done) begin
                if (!busy_q) begin
                    state_d = ST_A_SETUP;
                end else if (poll_cnt_q >= POLL_LIMIT) begin
                    timeout_d = 1'b1;
                    state_d   = ST_A_SETUP;
                end else begin
                    state_d = ST_P_SETUP;
                end
            end
            ST_A_SETUP: if (w_timer_done) state_d = ST_A_EH;
            ST_A_EH: if (w_timer_done) begin
                rd_sample_d = LCD_data;
                state_d     = ST_A_HOLD;
            end
            ST_A_HOLD: if (w_timer_done) begin
                state_d = ST_A_REC;
                if (req_rw_q == RW_READ) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = rd_sample_q;
                end
            end
            ST_A_REC: if (w_timer_done) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Pin registers follow the next state so they line up exactly with state_q.
        lcd_e_d  = (state_d == ST_P_EH) || (state_d == ST_A_EH);
        lcd_rs_d = lcd_rs_q;
        lcd_rw_d = lcd_rw_q;
        if (state_d == ST_P_SETUP && state_q != ST_P_SETUP) begin
            lcd_rs_d = RS_INSTR;
            lcd_rw_d = RW_READ;
        end else if (state_d == ST_A_SETUP && state_q != ST_A_SETUP) begin
            lcd_rs_d = req_rs_d;
            lcd_rw_d = req_rw_d;
        end
        drive_d     = (req_rw_d == RW_WRITE) &&
                      (state_d inside {ST_A_SETUP, ST_A_EH, ST_A_HOLD});
        cmd_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            req_rs_q    <= 1'b0;
            req_rw_q    <= 1'b1;
            req_data_q  <= '0;
            busy_q      <= 1'b0;
            poll_cnt_q  <= '0;
            rd_sample_q <= '0;
            lcd_e_q     <= 1'b0;
            lcd_rs_q    <= 1'b0;
            lcd_rw_q    <= 1'b1;
            drive_q     <= 1'b0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_rs_q    <= req_rs_d;
            req_rw_q    <= req_rw_d;
            req_data_q  <= req_data_d;
            busy_q      <= busy_d;
            poll_cnt_q  <= poll_cnt_d;
            rd_sample_q <= rd_sample_d;
            lcd_e_q     <= lcd_e_d;
            lcd_rs_q    <= lcd_rs_d;
            lcd_rw_q    <= lcd_rw_d;
            drive_q     <= drive_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            timeout_q   <= timeout_d;
        end
    end

    assign LCD_data     = drive_q ? req_data_q : 8'hzz;
    assign LCD_E        = lcd_e_q;
    assign LCD_RS       = lcd_rs_q;
    assign LCD_RW       = lcd_rw_q;
    assign cmd_ready    = cmd_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign busy_timeout = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_lcd_hd44780_sequencer.sv
// ============================================================================
// Module   : tb_lcd_hd44780_sequencer
// Brief    : Randomised bench with a behavioural HD44780 panel and timing model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_lcd_hd44780_sequencer;

    localparam int T_AS     = 2;
    localparam int T_EH     = 12;
    localparam int T_H      = 1;
    localparam int T_REC    = 10;
    localparam int POLL_MAX = 4;
    localparam int PHASE    = T_AS + T_EH + T_H + T_REC;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_rs = 1'b0;
    logic       cmd_rw = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_ready, rsp_valid, busy_timeout;
    logic [7:0] rsp_data;
    logic       LCD_E, LCD_RS, LCD_RW;
    wire  [7:0] LCD_data;

    // Panel model: answers reads while E is high; busy flag clears after busy_left polls.
    int         busy_left = 0;
    logic [6:0] ir_addr = 7'h00;
    logic [7:0] dr_val = 8'h00;

    assign LCD_data = (LCD_E && LCD_RW) ? (LCD_RS ? dr_val : {(busy_left != 0), ir_addr}) : 8'hzz;

    int         tests_run = 0;
    int         tests_failed = 0;
    logic [7:0] last_rsp = 8'h00;

    always #5 clk = ~clk;

    lcd_hd44780_sequencer #(
        .T_AS         (T_AS),
        .T_EH         (T_EH),
        .T_H          (T_H),
        .T_REC        (T_REC),
        .POLL_EN      (1),
        .POLL_MAX     (POLL_MAX)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_rs       (cmd_rs),
        .cmd_rw       (cmd_rw),
        .cmd_data     (cmd_data),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .busy_timeout (busy_timeout),
        .LCD_E        (LCD_E),
        .LCD_RS       (LCD_RS),
        .LCD_RW       (LCD_RW),
        .LCD_data     (LCD_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic bus_free();
        return $isunknown(LCD_data) || (LCD_data === 8'h00);
    endfunction

    task automatic run_txn(input string name, input logic rs, input logic rw,
                           input logic [7:0] wd, input int busy_polls,
                           input bit glitch, input logic [7:0] rdv);
        bit         skip, tmo;
        int         polls, lat, acc, k, wt, glitch_at, ready_at;
        int         e_pulses, bad_width, e_run, min_setup, stable, rsrw_e;
        int         drv_cycles, drv_first, drv_bad, rv_count, rv_at, to_count, to_at;
        logic [7:0] exp_rd, rv_data;
        logic       prev_e, prev_rs, prev_rw;

        skip  = (!rs && rw);
        polls = skip ? 0 : ((busy_polls + 1 < POLL_MAX) ? busy_polls + 1 : POLL_MAX);
        tmo   = !skip && (busy_polls >= POLL_MAX);
        lat   = PHASE * (polls + 1);
        acc   = PHASE * polls;
        dr_val    = rdv;
        ir_addr   = rdv[6:0];
        busy_left = busy_polls;
        exp_rd    = rs ? rdv : {(busy_polls != 0), rdv[6:0]};
        glitch_at = glitch ? int'($urandom_range(1, lat - 3)) : -10;

        wt = 0;
        while (!cmd_ready && wt < 300) begin
            @(negedge clk);
            wt++;
        end
        check({name, "/idle_ready"}, cmd_ready, 1);

        prev_e = LCD_E; prev_rs = LCD_RS; prev_rw = LCD_RW;
        cmd_valid = 1'b1; cmd_rs = rs; cmd_rw = rw; cmd_data = wd;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_rs = 1'($urandom); cmd_rw = 1'($urandom); cmd_data = 8'($urandom);

        e_pulses = 0; bad_width = 0; e_run = 0; min_setup = 1000; stable = 0; rsrw_e = 0;
        drv_cycles = 0; drv_first = -1; drv_bad = 0;
        rv_count = 0; rv_at = -1; rv_data = 8'h00; to_count = 0; to_at = -1; ready_at = -1;

        for (k = 0; k <= lat + 20; k++) begin
            if (k > 0) @(negedge clk);
            if (cmd_ready) begin
                ready_at = k;
                break;
            end
            if (LCD_E) begin
                if (!prev_e) begin
                    e_pulses++;
                    e_run = 0;
                    if (stable < min_setup) min_setup = stable;
                end
                e_run++;
                if (LCD_RS != prev_rs || LCD_RW != prev_rw) rsrw_e++;
            end else begin
                if (prev_e) begin
                    if (e_run != T_EH) bad_width++;
                    if (!prev_rs && prev_rw && busy_left > 0) busy_left--;
                end
                if (LCD_RS != prev_rs || LCD_RW != prev_rw) stable = 1;
                else stable++;
            end
            if (rsp_valid) begin rv_count++; rv_at = k; rv_data = rsp_data; end
            if (busy_timeout) begin to_count++; to_at = k; end
            if (!(LCD_E && LCD_RW) && !bus_free()) begin
                drv_cycles++;
                if (drv_first < 0) drv_first = k;
                if (LCD_data !== wd) drv_bad++;
            end
            prev_e = LCD_E; prev_rs = LCD_RS; prev_rw = LCD_RW;
            if (k == glitch_at) begin
                cmd_valid = 1'b1; cmd_rs = 1'($urandom); cmd_rw = 1'($urandom); cmd_data = ~wd;
            end else if (k == glitch_at + 1) begin
                cmd_valid = 1'b0;
            end
        end

        check({name, "/ready_latency"}, ready_at, lat);
        check({name, "/e_pulses"},      e_pulses, polls + 1);
        check({name, "/e_width_bad"},   bad_width, 0);
        check({name, "/setup_ok"},      min_setup >= T_AS, 1);
        check({name, "/rsrw_while_e"},  rsrw_e, 0);
        check({name, "/timeout_cnt"},   to_count, tmo ? 1 : 0);
        check({name, "/timeout_at"},    to_at, tmo ? acc : -1);
        check({name, "/rsp_cnt"},       rv_count, rw ? 1 : 0);
        check({name, "/rsp_at"},        rv_at, rw ? acc + T_AS + T_EH + T_H : -1);
        if (rw) check({name, "/rsp_pulse_data"}, rv_data, exp_rd);
        check({name, "/rsp_data_hold"}, rsp_data, rw ? exp_rd : last_rsp);
        check({name, "/drv_cycles"},    drv_cycles, rw ? 0 : T_AS + T_EH + T_H);
        check({name, "/drv_first"},     drv_first, rw ? -1 : acc);
        check({name, "/drv_data_bad"},  drv_bad, 0);
        if (rw) last_rsp = exp_rd;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", tests_run);
        $fatal(1, "watchdog");
    end

    initial begin
        logic       r_rs, r_rw;
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst/LCD_E", LCD_E, 0);
        check("rst/LCD_RS", LCD_RS, 0);
        check("rst/LCD_RW", LCD_RW, 1);
        check("rst/bus_free", bus_free(), 1);
        check("rst/cmd_ready", cmd_ready, 0);
        check("rst/rsp_valid", rsp_valid, 0);
        check("rst/rsp_data", rsp_data, 0);
        check("rst/busy_timeout", busy_timeout, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst/ready_after_release", cmd_ready, 1);

        run_txn("t1_write41",   1'b1, 1'b0, 8'h41, 0,   1'b0, 8'h00);
        run_txn("t2_busy3",     1'b1, 1'b0, 8'h42, 3,   1'b0, 8'h00);
        run_txn("t3_read5A",    1'b1, 1'b1, 8'h00, 0,   1'b0, 8'h5A);
        run_txn("t4_bf_read",   1'b0, 1'b1, 8'h00, 2,   1'b0, 8'h23);
        run_txn("t5_timeout",   1'b1, 1'b0, 8'h55, 100, 1'b0, 8'h00);

        for (int i = 0; i < 12; i++) begin
            r_rs = 1'($urandom);
            r_rw = 1'($urandom);
            run_txn($sformatf("rnd%0d", i), r_rs, r_rw, 8'($urandom_range(1, 255)),
                    int'($urandom_range(0, 5)), 1'b1, 8'($urandom));
        end

        // Abort a write in its access E-high phase with an asynchronous reset.
        busy_left = 0;
        cmd_valid = 1'b1; cmd_rs = 1'b1; cmd_rw = 1'b0; cmd_data = 8'h3C;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (PHASE + T_AS + 4) @(negedge clk);
        check("t6/pre_E_high", LCD_E, 1);
        check("t6/pre_bus_driven", bus_free(), 0);
        reset_n = 1'b0;
        #1;
        check("t6/E_drop", LCD_E, 0);
        check("t6/bus_free", bus_free(), 1);
        check("t6/RW_reset", LCD_RW, 1);
        check("t6/ready_low", cmd_ready, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("t6/ready_after_release", cmd_ready, 1);
        check("t6/E_idle", LCD_E, 0);
        check("t6/rsp_data_cleared", rsp_data, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
